// File: rtl/gates_bist_pkg.sv
// ---------------------------------------------------------------------------
// gates_bist_pkg
// Shared definitions for the gates BIST checker and its reference model:
//   - state_e      : checker FSM states (IDLE, RUN, DONE)
//   - NUM_VEC      : number of input vectors ({a,b} = 0..3)
//   - NUM_OUT      : number of outputs of the gates block (y1..y5)
//   - GOLDEN_TABLE : expected y[4:0] per vector, packed as
//                    GOLDEN_TABLE[idx*NUM_OUT +: NUM_OUT] with idx = {a,b}
// ---------------------------------------------------------------------------
package gates_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NUM_VEC = 4;
    localparam int NUM_OUT = 5;

    // Each 5-bit slice is {y5=NOR, y4=NAND, y3=XOR, y2=OR, y1=AND}.
    localparam logic [NUM_VEC*NUM_OUT-1:0] GOLDEN_TABLE = {
        5'b00011,   // {a,b} = 11
        5'b01110,   // {a,b} = 10
        5'b01110,   // {a,b} = 01
        5'b11000    // {a,b} = 00
    };

endpackage

// File: rtl/gates_bist_ref.sv
// ---------------------------------------------------------------------------
// gates_bist_ref
// Combinational golden model of the gates block, looked up from the packaged
// truth table.
// Ports:
//   a, b   : input vector
//   y_exp  : expected outputs, y_exp[0]=y1 ... y_exp[4]=y5
// ---------------------------------------------------------------------------
import gates_bist_pkg::*;

module gates_bist_ref (
    input  logic               a,
    input  logic               b,
    output logic [NUM_OUT-1:0] y_exp
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_bit
            assign y_exp[gi] = GOLDEN_TABLE[NUM_OUT * int'({a, b}) + gi];
        end
    endgenerate

endmodule

// File: rtl/gates_bist_checker.sv
// ---------------------------------------------------------------------------
// gates_bist_checker
// On-chip stimulus/response checker for the 2-input, 5-output gates block.
// Steps {a,b} through 00,01,10,11, holding each for HOLD_CYCLES cycles, and
// compares y against the golden table SETTLE_CYCLES cycles into each vector.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : single-cycle request to run the sequence (ignored in RUN)
//   a, b        : registered drive to the gates block
//   y           : gates outputs (combinational from a/b, same clock domain)
//   busy        : sequence in progress
//   done        : result valid, held until the next accepted start
//   pass        : done and no vector failed
//   err_vec     : bit i set if vector i mismatched
//   err_count   : number of failing vectors
// Build option:
//   GATES_BIST_CONT_CHECK_EN defined   -> compare every cycle from
//       cnt==SETTLE_CYCLES through cnt==HOLD_CYCLES-1; err_count counts each
//       failing vector once (first mismatch).
//   GATES_BIST_CONT_CHECK_EN undefined -> single compare at cnt==SETTLE_CYCLES.
// ---------------------------------------------------------------------------
import gates_bist_pkg::*;

module gates_bist_checker #(
    parameter int HOLD_CYCLES   = 200,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               a,
    output logic               b,
    input  logic [NUM_OUT-1:0] y,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_VEC-1:0] err_vec,
    output logic [2:0]         err_count
);

    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(HOLD_CYCLES - 1);

    state_e             state_reg, state_next;
    logic [1:0]         vec_reg, vec_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [NUM_VEC-1:0] err_vec_reg, err_vec_next;
    logic [2:0]         err_count_reg, err_count_next;

    logic [NUM_OUT-1:0] y_exp;
    logic               mismatch;
    logic               compare_en;

    // a/b come straight from the vector register: 00 in IDLE, the current
    // vector in RUN, and 11 in DONE because vec stays at 3 on exit.
    assign a = vec_reg[1];
    assign b = vec_reg[0];

    gates_bist_ref u_ref (
        .a     (a),
        .b     (b),
        .y_exp (y_exp)
    );

    // Case-inequality so X/Z on y counts as a failure.
    assign mismatch = (y !== y_exp);

`ifdef GATES_BIST_CONT_CHECK_EN
    assign compare_en = (cnt_reg >= SETTLE_CNT);
`else
    assign compare_en = (cnt_reg == SETTLE_CNT);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            vec_reg       <= 2'd0;
            cnt_reg       <= '0;
            err_vec_reg   <= '0;
            err_count_reg <= 3'd0;
        end else begin
            state_reg     <= state_next;
            vec_reg       <= vec_next;
            cnt_reg       <= cnt_next;
            err_vec_reg   <= err_vec_next;
            err_count_reg <= err_count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        vec_next       = vec_reg;
        cnt_next       = cnt_reg;
        err_vec_next   = err_vec_reg;
        err_count_next = err_count_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next     = RUN;
                    vec_next       = 2'd0;
                    cnt_next       = '0;
                    err_vec_next   = '0;
                    err_count_next = 3'd0;
                end
            end

            RUN: begin
                if (compare_en && mismatch) begin
                    err_vec_next[vec_reg] = 1'b1;
                    // Only the first mismatch of a vector is counted; in the
                    // single-compare build this is always the first one.
                    if (!err_vec_reg[vec_reg]) begin
                        err_count_next = err_count_reg + 3'd1;
                    end
                end

                if (cnt_reg == LAST_CNT) begin
                    cnt_next = '0;
                    if (vec_reg == 2'd3) begin
                        state_next = DONE;
                    end else begin
                        vec_next = vec_reg + 2'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state_reg == RUN);
    assign done      = (state_reg == DONE);
    assign pass      = (state_reg == DONE) && (err_count_reg == 3'd0);
    assign err_vec   = err_vec_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_gates_bist_checker.sv
// ---------------------------------------------------------------------------
// tb_gates_bist_checker
// Drives gates_bist_checker (HOLD_CYCLES=4, SETTLE_CYCLES=1) against a
// behavioural gates block with injectable stuck-at-0, per-vector flip and
// single-cycle glitch faults. Expected results are derived from the boolean
// gate definitions and the fault configuration.
// ---------------------------------------------------------------------------
module tb_gates_bist_checker;

    localparam int HOLD   = 4;
    localparam int SETTLE = 1;
    localparam int NVEC   = 4;
    localparam int RUN_LEN = HOLD * NVEC;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       a, b;
    logic [4:0] y;
    logic       busy, done, pass;
    logic [3:0] err_vec;
    logic [2:0] err_count;

    // Fault injection controls for the behavioural gates block.
    logic [4:0] stuck0;
    logic [4:0] flip [4];
    logic [4:0] glitch;

    int vectors;
    int miscompares;

    gates_bist_checker #(
        .HOLD_CYCLES   (HOLD),
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_vec   (err_vec),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] gates_golden(input logic ia, input logic ib);
        return {~(ia | ib), ~(ia & ib), ia ^ ib, ia | ib, ia & ib};
    endfunction

    always_comb begin
        y = ((gates_golden(a, b) & ~stuck0) ^ flip[{a, b}]) ^ glitch;
    end

    // Reference: what the checker should report for the current fault setup
    // plus an optional one-cycle glitch at RUN cycle glitch_at.
    function automatic void model(input int glitch_at, input logic [4:0] gmask,
                                  output logic [3:0] ev, output int cnt);
        ev  = 4'b0000;
        cnt = 0;
        for (int v = 0; v < NVEC; v++) begin
            logic [4:0] g, f;
            logic       bad;
            logic       gl_here;
            int         gl_pos;
            g  = gates_golden(v[1], v[0]);
            f  = (g & ~stuck0) ^ flip[v];
            gl_here = (glitch_at >= 0) && (glitch_at / HOLD == v);
            gl_pos  = glitch_at % HOLD;
`ifdef GATES_BIST_CONT_CHECK_EN
            bad = (f != g) || (gl_here && gl_pos >= SETTLE && ((f ^ gmask) != g));
`else
            if (gl_here && gl_pos == SETTLE) bad = ((f ^ gmask) != g);
            else                             bad = (f != g);
`endif
            if (bad) begin
                ev[v] = 1'b1;
                cnt++;
            end
        end
    endfunction

    task automatic clear_faults();
        stuck0 = 5'b0;
        glitch = 5'b0;
        for (int v = 0; v < NVEC; v++) flip[v] = 5'b0;
    endtask

    // One full start..DONE run, checked cycle by cycle. Negative arguments
    // disable the restart pulse, reset, or glitch.
    task automatic run_seq(input string name, input int restart_at, input int reset_at,
                           input int glitch_at, input logic [4:0] gmask);
        logic [3:0] exp_ev;
        int         exp_cnt;
        model(glitch_at, gmask, exp_ev, exp_cnt);

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int t = 0; t < RUN_LEN; t++) begin
            logic [1:0] v;
            v = 2'(t / HOLD);
            vectors++;
            if ({a, b} !== v) begin
                miscompares++;
                $display("FAIL %s ab t=%0d: got %b%b want %b", name, t, a, b, v);
            end
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s busy/done t=%0d: got %b/%b want 1/0", name, t, busy, done);
            end
            if (t == 0) begin
                vectors++;
                if (err_vec !== 4'b0 || err_count !== 3'd0) begin
                    miscompares++;
                    $display("FAIL %s clear_on_start: err_vec=%b err_count=%0d want 0000/0",
                             name, err_vec, err_count);
                end
            end
            if (t == reset_at) begin
                rst_n = 1'b0;
                #1;
                vectors++;
                if ({a, b, busy, done, pass, err_vec, err_count} !== 12'b0) begin
                    miscompares++;
                    $display("FAIL %s async_reset: ab=%b%b busy=%b done=%b pass=%b ev=%b ec=%0d want all 0",
                             name, a, b, busy, done, pass, err_vec, err_count);
                end
                @(negedge clk) rst_n = 1'b1;
                $display("run %-12s : reset at RUN cycle %0d, outputs cleared", name, t);
                return;
            end
            glitch = (t == glitch_at) ? gmask : 5'b0;
            start  = (t == restart_at);
            @(negedge clk);
        end
        glitch = 5'b0;
        start  = 1'b0;

        vectors++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s end_of_run: busy=%b done=%b want 0/1", name, busy, done);
        end
        vectors++;
        if (pass !== (exp_cnt == 0) || err_vec !== exp_ev || err_count !== 3'(exp_cnt)) begin
            miscompares++;
            $display("FAIL %s result: pass=%b ev=%b ec=%0d want pass=%b ev=%b ec=%0d",
                     name, pass, err_vec, err_count, (exp_cnt == 0), exp_ev, exp_cnt);
        end
        @(negedge clk);
        vectors++;
        if ({a, b} !== 2'b11 || done !== 1'b1 || err_vec !== exp_ev) begin
            miscompares++;
            $display("FAIL %s done_hold: ab=%b%b done=%b ev=%b want 11/1/%b",
                     name, a, b, done, err_vec, exp_ev);
        end
        $display("run %-12s : pass=%b err_vec=%b err_count=%0d (expected %b/%0d)",
                 name, pass, err_vec, err_count, exp_ev, exp_cnt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        clear_faults();
        repeat (2) @(negedge clk);
        vectors++;
        if ({a, b, busy, done, pass, err_vec, err_count} !== 12'b0) begin
            miscompares++;
            $display("FAIL reset_state: ab=%b%b busy=%b done=%b pass=%b ev=%b ec=%0d want all 0",
                     a, b, busy, done, pass, err_vec, err_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%b done=%b want 0/0", busy, done);
        end
        $display("reset          : outputs checked");
    endtask

    task automatic test_clean();
        clear_faults();
        run_seq("clean", -1, -1, -1, 5'b0);
    endtask

    task automatic test_stuck_y3();
        clear_faults();
        stuck0 = 5'b00100;
        run_seq("y3_stuck0", -1, -1, -1, 5'b0);
        vectors++;
        if (err_vec !== 4'b0110 || err_count !== 3'd2 || pass !== 1'b0) begin
            miscompares++;
            $display("FAIL y3_stuck0_literal: ev=%b ec=%0d pass=%b want 0110/2/0",
                     err_vec, err_count, pass);
        end
        clear_faults();
    endtask

    task automatic test_restart_ignored();
        clear_faults();
        run_seq("restart_run", 6, -1, -1, 5'b0);
    endtask

    task automatic test_reset_mid_run();
        clear_faults();
        run_seq("reset_vec2", -1, 9, -1, 5'b0);
        run_seq("after_reset", -1, -1, -1, 5'b0);
    endtask

    task automatic test_back_to_back();
        clear_faults();
        flip[2] = 5'b10000;
        run_seq("prior_fail", -1, -1, -1, 5'b0);
        clear_faults();
        run_seq("rerun_clean", -1, -1, -1, 5'b0);
    endtask

    task automatic test_glitch();
        clear_faults();
        // Vector 11, cnt 3 is RUN cycle 15.
        run_seq("glitch_y1", -1, -1, 15, 5'b00001);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int         gat;
            logic [4:0] gm;
            clear_faults();
            for (int v = 0; v < NVEC; v++)
                if ($urandom_range(0, 2) == 0) flip[v] = 5'($urandom_range(1, 31));
            if ($urandom_range(0, 3) == 0) stuck0 = 5'($urandom_range(1, 31));
            gat = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, RUN_LEN - 1)) : -1;
            gm  = 5'($urandom_range(1, 31));
            run_seq($sformatf("random_%0d", i), -1, -1, gat, gm);
        end
        clear_faults();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_clean();
        test_stuck_y3();
        test_restart_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_glitch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gates_bist_checker.md
Name: gates_bist_checker

Overview:
- Self-checking stimulus/response block for the 2-input, 5-output `gates` block.
- Drives the DUT's `a`/`b` inputs and holds each vector for a fixed window. Samples `y1..y5`, compares them against a golden truth table and reports pass/fail with per-vector error flags.
- Sits beside the `gates` instance as on-chip BIST. It replaces bench-only stimulus, so the same check runs in simulation and on FPGA.

Parameters:
- HOLD_CYCLES, 200, clock cycles each input vector is held (legal ≥ SETTLE_CYCLES+1).
- SETTLE_CYCLES, 2, cycles after vector change before the sample/compare point (legal ≥ 1).
- CNT_W, 8, hold-counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to run the 4-vector sequence.
- a  output  1  drive to DUT input a.
- b  output  1  drive to DUT input b.
- y  input  5  DUT outputs, with y[0]=y1 … y[4]=y5.
- busy  output  1  sequence in progress.
- done  output  1  level; result valid, held until the next accepted start.
- pass  output  1  1 when done and no vector failed.
- err_vec  output  4  bit i set if vector i ({a,b}=i) mismatched.
- err_count  output  3  number of failing vectors, 0..4.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_vec=0, err_count=0.
  - Internal hold counter and vector index are cleared.
- Golden table, per vector {a,b}:
  - y1 = a AND b
  - y2 = a OR b
  - y3 = a XOR b
  - y4 = a NAND b
  - y5 = a NOR b
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at an edge: next cycle state=RUN, busy=1, vec=0 ({a,b}=00), cnt=0, err_vec=0, err_count=0, done=0, pass=0.
- RUN:
  - {a,b} are registered outputs equal to vec.
  - cnt increments each cycle from 0 to HOLD_CYCLES-1.
  - When cnt==SETTLE_CYCLES, y is compared against the golden value for vec. On mismatch, err_vec[vec] is set and err_count increments, both registered.
  - When cnt==HOLD_CYCLES-1 and vec<3: vec increments and cnt resets to 0.
  - When cnt==HOLD_CYCLES-1 and vec==3: state goes to DONE.
  - busy is high for exactly 4*HOLD_CYCLES cycles.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - a/b hold at 11.
  - start=1 restarts exactly as from IDLE (done drops the cycle RUN is entered).
- start while RUN: ignored; no restart, no error.
- The y input is treated as combinational from the registered a/b. There are no synchronizers; the DUT must sit in the same clock domain.
- X/Z on y at the compare point counts as a mismatch (use case-inequality compare).
- Reset asserted mid-RUN: immediate return to reset values; the partial result is discarded.

Optional Feature:
- Macro: GATES_BIST_CONT_CHECK_EN.
- Defined: comparison is performed every cycle with SETTLE_CYCLES ≤ cnt ≤ HOLD_CYCLES-1. Any mismatch in that window sets err_vec[vec]. err_count increments at most once per vector, on the first mismatch only (this catches glitching/unstable outputs).
- Undefined: single compare at cnt==SETTLE_CYCLES only.

Decomposition:
- Shared package gates_bist_pkg:
  - State enum (IDLE, RUN, DONE).
  - NUM_VEC=4 and NUM_OUT=5.
  - 20-bit GOLDEN_TABLE constant indexed by {a,b}.
- One sub-module gates_bist_ref: combinational {a,b} → expected y[4:0], built from the package constant. It is reused by other benches.

Test Plan (bench uses HOLD_CYCLES=4, SETTLE_CYCLES=1, correct `gates` DUT unless stated):
- Reset then one start pulse:
  - a/b sequence is 00,01,10,11 at 4 cycles each.
  - busy high for 16 cycles, then done=1, pass=1, err_vec=0000, err_count=0.
- DUT y3 forced to constant 0:
  - Vectors 01 and 10 fail.
  - done with pass=0, err_vec=0110, err_count=2.
- start pulsed again at cycle 6 of RUN:
  - Ignored; busy still falls after 16 cycles total from the first start.
- rst_n dropped during vector 2:
  - Outputs return to reset values immediately.
  - A later start runs a clean full sequence with pass=1.
- From DONE with a prior failure, issue start with a correct DUT:
  - done drops the next cycle, err_vec clears.
  - Final result is pass=1.
- With GATES_BIST_CONT_CHECK_EN, y1 glitched to wrong value for one cycle at cnt=3 of vector 11:
  - err_vec=1000, err_count=1.
  - The same stimulus without the macro gives pass=1.
